rx_word_assembler: RTL and testbench



---
 rtl/rx_pkg.sv | 16 +
 rtl/rx_sync_fifo.sv | 59 +++++
 rtl/rx_word_assembler.sv | 147 ++++++++++++++
 tb/tb_rx_word_assembler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - K codes and FIFO entry type shared by the rx word assembler
package rx_pkg;

    localparam logic [7:0] K_SOF  = 8'hFC;
    localparam logic [7:0] K_EOF  = 8'hBC;
    localparam logic [7:0] K_IDLE = 8'h3C;

    localparam int MAX_BYTES = 8;

    // Sized for the widest word; narrower builds leave the upper data bits zero.
    typedef struct packed {
        logic                   sof;
        logic [8*MAX_BYTES-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_sync_fifo.sv
// rtl/rx_sync_fifo.sv - single-clock fall-through FIFO of rx entries with occupancy
module rx_sync_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  rx_entry_t push_entry,
    input  logic      pop,
    output rx_entry_t head,
    output logic      full,
    output logic      empty,
    output logic [AW:0] size
);

    rx_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (size == (AW+1)'(DEPTH));
    assign empty   = (size == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   size <= size + 1'b1;
                2'b01:   size <= size - 1'b1;
                default: size <= size;
            endcase
        end
    end

    // Gating on empty keeps the head at zero after reset without clearing the array.
    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_word_assembler.sv
// rtl/rx_word_assembler.sv - decoded bytes to BYTES-wide words with error counters; RX_FRAME_TAG_EN enables SOF tagging
module rx_word_assembler
    import rx_pkg::*;
#(
    parameter int BYTES     = 3,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     WCLK,
    input  logic                     RESET,
    input  logic                     SYM_VALID,
    input  logic                     SYM_K,
    input  logic [7:0]               SYM_DATA,
    input  logic                     SYM_ERR,
    output logic [8*BYTES-1:0]       OUT_DATA,
    output logic                     OUT_SOF,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   FIFO_SIZE,
    output logic [CNT_WIDTH-1:0]     DECODER_ERR_CNT,
    output logic [CNT_WIDTH-1:0]     FRAME_ERR_CNT,
    output logic [CNT_WIDTH-1:0]     LOST_ERR_CNT
);

    localparam int              SEL_W    = $clog2(BYTES);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BYTES - 1);

    logic [SEL_W-1:0]       byte_sel;
    logic [8*(BYTES-1)-1:0] word_buf;
    logic                   stage_valid;
    logic [8*BYTES-1:0]     stage_data;
    logic                   stage_sof;
    logic                   is_err;
    logic                   is_k;
    logic                   is_data;
    logic                   complete;
    logic                   fifo_full;
    logic                   fifo_empty;
    rx_entry_t              push_entry;
    rx_entry_t              head;

    assign is_err   = SYM_VALID && SYM_ERR;
    assign is_k     = SYM_VALID && !SYM_ERR && SYM_K;
    assign is_data  = SYM_VALID && !SYM_ERR && !SYM_K;
    assign complete = is_data && (byte_sel == LAST_SEL);

    // word_buf holds slots 0..BYTES-2; the final byte goes straight into the stage.
    always_ff @(posedge WCLK) begin
        if (RESET) begin
            byte_sel    <= '0;
            word_buf    <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= complete;
            if (complete) begin
                stage_data <= {word_buf, SYM_DATA};
                byte_sel   <= '0;
            end else if (is_data) begin
                for (int i = 0; i < BYTES - 1; i++) begin
                    if (byte_sel == SEL_W'(i)) begin
                        word_buf[8*(BYTES-2-i) +: 8] <= SYM_DATA;
                    end
                end
                byte_sel <= byte_sel + 1'b1;
            end else if (is_k || is_err) begin
                byte_sel <= '0;
            end
        end
    end

`ifdef RX_FRAME_TAG_EN
    logic sof_pend;

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            sof_pend      <= 1'b0;
            stage_sof     <= 1'b0;
            FRAME_ERR_CNT <= '0;
        end else begin
            if (is_err || complete) begin
                sof_pend <= 1'b0;
            end else if (is_k && SYM_DATA == K_SOF) begin
                sof_pend <= 1'b1;
            end else if (is_k && SYM_DATA == K_EOF) begin
                sof_pend <= 1'b0;
            end
            if (complete) begin
                stage_sof <= sof_pend;
            end
            if (is_k && byte_sel != '0 && FRAME_ERR_CNT != '1) begin
                FRAME_ERR_CNT <= FRAME_ERR_CNT + 1'b1;
            end
        end
    end
`else
    assign stage_sof     = 1'b0;
    assign FRAME_ERR_CNT = '0;
`endif

    // A full FIFO at the push edge drops the word even if the head pops that edge.
    always_ff @(posedge WCLK) begin
        if (RESET) begin
            DECODER_ERR_CNT <= '0;
            LOST_ERR_CNT    <= '0;
        end else begin
            if (is_err && DECODER_ERR_CNT != '1) begin
                DECODER_ERR_CNT <= DECODER_ERR_CNT + 1'b1;
            end
            if (stage_valid && fifo_full && LOST_ERR_CNT != '1) begin
                LOST_ERR_CNT <= LOST_ERR_CNT + 1'b1;
            end
        end
    end

    always_comb begin
        push_entry                    = '0;
        push_entry.sof                = stage_sof;
        push_entry.data[8*BYTES-1:0]  = stage_data;
    end

    rx_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (WCLK),
        .reset      (RESET),
        .push       (stage_valid),
        .push_entry (push_entry),
        .pop        (OUT_VALID && OUT_READY),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .size       (FIFO_SIZE)
    );

    assign OUT_VALID = !fifo_empty;
    assign OUT_DATA  = head.data[8*BYTES-1:0];
    assign OUT_SOF   = head.sof;

    generate
        if (BYTES < MAX_BYTES) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^head.data[8*MAX_BYTES-1:8*BYTES];
        end
    endgenerate

endmodule

// File: tb/tb_rx_word_assembler.sv
// tb/tb_rx_word_assembler.sv - self-checking bench for rx_word_assembler
module tb_rx_word_assembler;

    localparam int BYTES     = 3;
    localparam int DEPTH     = 8;
    localparam int CNT_WIDTH = 8;
    localparam int W         = 8 * BYTES;
    localparam int CMAX      = (1 << CNT_WIDTH) - 1;
`ifdef RX_FRAME_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic                   WCLK = 1'b0;
    logic                   RESET = 1'b1;
    logic                   SYM_VALID = 1'b0;
    logic                   SYM_K = 1'b0;
    logic [7:0]             SYM_DATA = 8'h00;
    logic                   SYM_ERR = 1'b0;
    logic                   OUT_READY = 1'b0;
    logic [W-1:0]           OUT_DATA;
    logic                   OUT_SOF;
    logic                   OUT_VALID;
    logic [$clog2(DEPTH):0] FIFO_SIZE;
    logic [CNT_WIDTH-1:0]   DECODER_ERR_CNT;
    logic [CNT_WIDTH-1:0]   FRAME_ERR_CNT;
    logic [CNT_WIDTH-1:0]   LOST_ERR_CNT;

    always #5 WCLK = ~WCLK;

    rx_word_assembler #(
        .BYTES     (BYTES),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .WCLK            (WCLK),
        .RESET           (RESET),
        .SYM_VALID       (SYM_VALID),
        .SYM_K           (SYM_K),
        .SYM_DATA        (SYM_DATA),
        .SYM_ERR         (SYM_ERR),
        .OUT_DATA        (OUT_DATA),
        .OUT_SOF         (OUT_SOF),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .FIFO_SIZE       (FIFO_SIZE),
        .DECODER_ERR_CNT (DECODER_ERR_CNT),
        .FRAME_ERR_CNT   (FRAME_ERR_CNT),
        .LOST_ERR_CNT    (LOST_ERR_CNT)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte lists and a word queue, stepped once per clock edge.
    logic [7:0]  m_bytes[$];
    logic [63:0] m_q[$];
    logic [63:0] m_stage;
    bit          m_stage_v;
    bit          m_sof_pend;
    int          m_dec;
    int          m_frame;
    int          m_lost;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    always @(posedge WCLK) begin
        bit          was_full;
        logic [63:0] w;
        if (RESET) begin
            m_bytes.delete();
            m_q.delete();
            m_stage_v  = 0;
            m_sof_pend = 0;
            m_dec      = 0;
            m_frame    = 0;
            m_lost     = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (m_q.size() > 0 && OUT_READY) void'(m_q.pop_front());
            if (m_stage_v) begin
                if (was_full) m_lost = sat(m_lost);
                else m_q.push_back(m_stage);
            end
            m_stage_v = 0;
            if (SYM_VALID) begin
                if (SYM_ERR) begin
                    m_dec = sat(m_dec);
                    m_bytes.delete();
                    m_sof_pend = 0;
                end else if (SYM_K) begin
                    if (TAG_EN && m_bytes.size() != 0) m_frame = sat(m_frame);
                    m_bytes.delete();
                    if (SYM_DATA == 8'hFC) m_sof_pend = 1;
                    else if (SYM_DATA == 8'hBC) m_sof_pend = 0;
                end else begin
                    m_bytes.push_back(SYM_DATA);
                    if (m_bytes.size() == BYTES) begin
                        w = '0;
                        foreach (m_bytes[i]) w = (w << 8) | 64'(m_bytes[i]);
                        w[W] = TAG_EN & m_sof_pend;
                        m_stage    = w;
                        m_stage_v  = 1;
                        m_sof_pend = 0;
                        m_bytes.delete();
                    end
                end
            end
        end
    end

    bit          run_cmp = 0;
    logic [63:0] got[$];

    always @(negedge WCLK) begin
        if (run_cmp) begin
            chk("out_valid", 64'(OUT_VALID), 64'(m_q.size() != 0));
            chk("fifo_size", 64'(FIFO_SIZE), 64'(m_q.size()));
            if (m_q.size() != 0) begin
                chk("out_data", 64'(OUT_DATA), 64'(m_q[0][W-1:0]));
                chk("out_sof", 64'(OUT_SOF), 64'(m_q[0][W]));
            end
            chk("decoder_err_cnt", 64'(DECODER_ERR_CNT), 64'(m_dec));
            chk("frame_err_cnt", 64'(FRAME_ERR_CNT), 64'(m_frame));
            chk("lost_err_cnt", 64'(LOST_ERR_CNT), 64'(m_lost));
            if (OUT_VALID === 1'b1 && OUT_READY) got.push_back({39'd0, OUT_SOF, OUT_DATA});
        end
    end

    function automatic logic [63:0] gw(input int i);
        return (i < got.size()) ? got[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic sym(input bit k, input bit err, input logic [7:0] d);
        SYM_VALID = 1'b1;
        SYM_K     = k;
        SYM_ERR   = err;
        SYM_DATA  = d;
        @(posedge WCLK);
        #1;
    endtask

    task automatic idle(input int n);
        SYM_VALID = 1'b0;
        SYM_K     = 1'b0;
        SYM_ERR   = 1'b0;
        repeat (n) begin
            @(posedge WCLK);
            #1;
        end
    endtask

    task automatic do_reset();
        SYM_VALID = 1'b0;
        RESET     = 1'b1;
        @(posedge WCLK);
        #1;
        RESET = 1'b0;
        got.delete();
    endtask

    logic [63:0] exp_w;

    initial begin
        @(posedge WCLK);
        #1;
        run_cmp = 1;
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_data", 64'(OUT_DATA), 64'd0);
        chk("rst_size", 64'(FIFO_SIZE), 64'd0);
        chk("rst_counters", {40'd0, DECODER_ERR_CNT, FRAME_ERR_CNT, LOST_ERR_CNT}, 64'd0);
        RESET = 1'b0;

        // SOF then two words, latency and tagging
        OUT_READY = 1'b1;
        sym(1, 0, 8'hFC);
        sym(0, 0, 8'h11);
        sym(0, 0, 8'h22);
        sym(0, 0, 8'h33);
        chk("t1_valid_at_n", 64'(OUT_VALID), 64'd0);
        sym(0, 0, 8'h44);
        chk("t1_valid_at_n1", 64'(OUT_VALID), 64'd1);
        chk("t1_head_data", 64'(OUT_DATA), 64'h112233);
        chk("t1_head_sof", 64'(OUT_SOF), 64'(TAG_EN));
        sym(0, 0, 8'h55);
        sym(0, 0, 8'h66);
        idle(4);
        chk("t1_count", 64'(got.size()), 64'd2);
        chk("t1_w0", gw(0), (64'(TAG_EN) << 24) | 64'h112233);
        chk("t1_w1", gw(1), 64'h445566);

        // Partial word cut by a K code
        do_reset();
        sym(0, 0, 8'hAA);
        sym(0, 0, 8'hBB);
        sym(1, 0, 8'h3C);
        sym(0, 0, 8'hCC);
        sym(0, 0, 8'hDD);
        sym(0, 0, 8'hEE);
        idle(4);
        chk("t2_count", 64'(got.size()), 64'd1);
        chk("t2_w0", gw(0), 64'hCCDDEE);
        chk("t2_frame_err", 64'(FRAME_ERR_CNT), TAG_EN ? 64'd1 : 64'd0);

        // Decoder error mid-word
        do_reset();
        sym(0, 0, 8'h01);
        sym(0, 1, 8'h55);
        sym(0, 0, 8'h02);
        sym(0, 0, 8'h03);
        sym(0, 0, 8'h04);
        idle(4);
        chk("t3_count", 64'(got.size()), 64'd1);
        chk("t3_w0", gw(0), 64'h020304);
        chk("t3_dec_err", 64'(DECODER_ERR_CNT), 64'd1);
        chk("t3_frame_err", 64'(FRAME_ERR_CNT), 64'd0);

        // Overflow with a stalled consumer, then drain
        do_reset();
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sym(0, 0, 8'(3*i + 1));
            sym(0, 0, 8'(3*i + 2));
            sym(0, 0, 8'(3*i + 3));
        end
        idle(4);
        chk("t4_size_full", 64'(FIFO_SIZE), 64'd8);
        chk("t4_lost", 64'(LOST_ERR_CNT), 64'd2);
        OUT_READY = 1'b1;
        idle(12);
        chk("t4_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            exp_w = (64'(3*i + 1) << 16) | (64'(3*i + 2) << 8) | 64'(3*i + 3);
            chk($sformatf("t4_w%0d", i), gw(i), exp_w);
        end
        chk("t4_size_empty", 64'(FIFO_SIZE), 64'd0);

        // Decoder counter saturation
        do_reset();
        repeat (300) sym(0, 1, 8'h00);
        idle(2);
        chk("t5_dec_sat", 64'(DECODER_ERR_CNT), 64'd255);

        // Reset in the middle of a word
        do_reset();
        sym(0, 0, 8'hA1);
        sym(0, 0, 8'hA2);
        do_reset();
        sym(0, 0, 8'hB1);
        sym(0, 0, 8'hB2);
        sym(0, 0, 8'hB3);
        idle(4);
        chk("t6_count", 64'(got.size()), 64'd1);
        chk("t6_w0", gw(0), 64'hB1B2B3);
        chk("t6_counters", {40'd0, DECODER_ERR_CNT, FRAME_ERR_CNT, LOST_ERR_CNT}, 64'd0);

        run_cmp = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
